// File: rtl/sysid_regs_if.sv
// Register-bus bundle for sysid_regs: request signals from the master,
// plus registered read data and its qualifier from the slave.
interface sysid_regs_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_regs.sv
// System ID / build timestamp / scratch register block with fixed-latency reads.
// Define SYSID_UPTIME_EN to build the uptime counter, its HI shadow and the CTRL register.
module sysid_regs #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 3,
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'd1730297458,
    parameter int unsigned READ_LATENCY = 1
) (
    input logic         clock,
    input logic         reset,
    sysid_regs_if.slave bus
);
    localparam int unsigned BE_W = DATA_W / 8;

    if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
        $error("sysid_regs: DATA_W must be 32 or 64");
    end
    if (ADDR_W < 3) begin : g_bad_addr_w
        $error("sysid_regs: ADDR_W must be at least 3");
    end
    if (!(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : g_bad_latency
        $error("sysid_regs: READ_LATENCY must be 1 or 2");
    end

    // A read colliding with a write is discarded; reset priority is applied in the flops.
    logic rd_acc;
    logic wr_acc;
    assign rd_acc = bus.read & ~bus.write;
    assign wr_acc = bus.write;

    logic [DATA_W-1:0] scratch_q, scratch_d;
    logic              scratch_wr;

    assign scratch_wr = wr_acc && (bus.address == ADDR_W'(3));

    always_comb begin
        scratch_d = scratch_q;
        for (int i = 0; i < BE_W; i++) begin
            if (scratch_wr && bus.byteenable[i]) begin
                scratch_d[8*i +: 8] = bus.writedata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch_q <= '0;
        end else begin
            scratch_q <= scratch_d;
        end
    end

`ifdef SYSID_UPTIME_EN
    localparam logic UptimeEn = 1'b1;

    logic [2*DATA_W-1:0] uptime_q, uptime_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic                freeze_q, freeze_d;
    logic                ctrl_wr;
    logic                clear_req;

    always_comb begin
        ctrl_wr   = wr_acc && (bus.address == ADDR_W'(6)) && bus.byteenable[0];
        clear_req = ctrl_wr && bus.writedata[0];
        freeze_d  = ctrl_wr ? bus.writedata[1] : freeze_q;
        // CLEAR wins over FREEZE so a combined write parks the counter at zero.
        if (clear_req) begin
            uptime_d = '0;
        end else if (freeze_q) begin
            uptime_d = uptime_q;
        end else begin
            uptime_d = uptime_q + (2*DATA_W)'(1);
        end
        shadow_d = shadow_q;
        if (rd_acc && (bus.address == ADDR_W'(4))) begin
            shadow_d = uptime_q[2*DATA_W-1:DATA_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            uptime_q <= '0;
            shadow_q <= '0;
            freeze_q <= 1'b0;
        end else begin
            uptime_q <= uptime_d;
            shadow_q <= shadow_d;
            freeze_q <= freeze_d;
        end
    end
`else
    localparam logic UptimeEn = 1'b0;
`endif

    logic [DATA_W-1:0] info_val;
    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        info_val        = '0;
        info_val[7:0]   = 8'(DATA_W);
        info_val[9:8]   = 2'(READ_LATENCY);
        info_val[10]    = UptimeEn;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_W'(0): rd_mux = DATA_W'(SYSTEM_ID);
            ADDR_W'(1): rd_mux = DATA_W'(TIMESTAMP);
            ADDR_W'(2): rd_mux = info_val;
            ADDR_W'(3): rd_mux = scratch_q;
`ifdef SYSID_UPTIME_EN
            ADDR_W'(4): rd_mux = uptime_q[DATA_W-1:0];
            ADDR_W'(5): rd_mux = shadow_q;
            ADDR_W'(6): rd_mux = {{(DATA_W-2){1'b0}}, freeze_q, 1'b0};
`endif
            default:    rd_mux = '0;
        endcase
    end

    logic              pipe_vld;
    logic [DATA_W-1:0] pipe_data;

    if (READ_LATENCY == 2) begin : g_lat2
        logic              s1_vld_q;
        logic [DATA_W-1:0] s1_data_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                s1_vld_q  <= 1'b0;
                s1_data_q <= '0;
            end else begin
                s1_vld_q <= rd_acc;
                if (rd_acc) begin
                    s1_data_q <= rd_mux;
                end
            end
        end

        assign pipe_vld  = s1_vld_q;
        assign pipe_data = s1_data_q;
    end else begin : g_lat1
        assign pipe_vld  = rd_acc;
        assign pipe_data = rd_mux;
    end

    logic [DATA_W-1:0] readdata_q;
    logic              readdatavalid_q;

    // readdata only moves on a valid beat so it holds between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            readdatavalid_q <= pipe_vld;
            if (pipe_vld) begin
                readdata_q <= pipe_data;
            end
        end
    end

    assign bus.readdata      = readdata_q;
    assign bus.readdatavalid = readdatavalid_q;
endmodule

// File: tb/tb_sysid_regs.sv
// Scoreboard bench for sysid_regs: driver pushes model-predicted read data with its due cycle,
// a negedge monitor pops and compares on every readdatavalid and checks hold otherwise.
`timescale 1ns/1ps
module tb_sysid_regs;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 3;
    localparam int unsigned RL  = 2;
    localparam logic [31:0] SID = 32'hCAFE_0001;
    localparam logic [31:0] TS  = 32'd1730297458;
`ifdef SYSID_UPTIME_EN
    localparam bit UP = 1'b1;
`else
    localparam bit UP = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sysid_regs_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sysid_regs #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .SYSTEM_ID   (SID),
        .TIMESTAMP   (TS),
        .READ_LATENCY(RL)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    // Reference state
    logic [31:0] m_scratch = '0;
    logic        m_freeze  = 1'b0;
    logic [63:0] m_cnt     = '0;
    logic [31:0] m_shadow  = '0;
    logic [31:0] m_hold    = '0;
    exp_t        exp_q[$];

    int unsigned ncyc     = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          mon_en   = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            3'd0: v = SID;
            3'd1: v = TS;
            3'd2: v = {21'd0, UP, 2'(RL), 8'(DW)};
            3'd3: v = m_scratch;
            3'd4: v = UP ? m_cnt[31:0] : 32'd0;
            3'd5: v = UP ? m_shadow : 32'd0;
            3'd6: v = UP ? {30'd0, m_freeze, 1'b0} : 32'd0;
            default: v = '0;
        endcase
        return v;
    endfunction

    // One clock: drive, let the edge happen, then advance the model to match.
    task automatic step(input bit r, input bit w, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] be, input bit rs);
        exp_t e;
        bit   ctrl_wr;
        bus.read       = r;
        bus.write      = w;
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = be;
        rst            = rs;
        @(posedge clk);
        if (rs) begin
            m_scratch = '0;
            m_freeze  = 1'b0;
            m_cnt     = '0;
            m_shadow  = '0;
            m_hold    = '0;
            exp_q.delete();
        end else begin
            if (r && !w) begin
                e.data = model_read(a);
                e.due  = ncyc + RL - 1;
                exp_q.push_back(e);
                if (a == 3'd4) m_shadow = m_cnt[63:32];
            end
            if (w && a == 3'd3) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
                end
            end
            ctrl_wr = UP && w && (a == 3'd6) && be[0];
            if (ctrl_wr && d[0]) m_cnt = '0;
            else if (!m_freeze) m_cnt = m_cnt + 64'd1;
            if (ctrl_wr) m_freeze = d[1];
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b1, 1'b0, a, 32'd0, 4'd0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b0, 1'b1, a, d, be, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.readdatavalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_readdatavalid", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("readdata", {32'd0, bus.readdata}, {32'd0, e.data});
                    check("latency", 64'(ncyc), 64'(e.due));
                    m_hold = e.data;
                end
            end else begin
                check("readdata_hold", {32'd0, bus.readdata}, {32'd0, m_hold});
            end
        end
        ncyc++;
    end

    initial begin
        logic [AW-1:0] a;
        bit            r, w, rs;

        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0;
        bus.writedata = '0; bus.byteenable = '0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b1);
        check("reset_readdata", {32'd0, bus.readdata}, 64'd0);
        check("reset_readdatavalid", {63'd0, bus.readdatavalid}, 64'd0);
        mon_en = 1'b1;
        idle(2);

        // Constants, back to back
        rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd7);
        idle(4);

        // SCRATCH byte lanes
        wr(3'd3, 32'h1234_5678, 4'b1111);
        wr(3'd3, 32'hAABB_CCDD, 4'b0101);
        rd(3'd3);
        idle(3);
        check("scratch_model", {32'd0, m_scratch}, 64'h12BB_56DD);

`ifdef SYSID_UPTIME_EN
        // Rollover through a forced preload while frozen
        wr(3'd6, 32'h2, 4'b0001);
        force dut.uptime_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.uptime_q;
        m_cnt = 64'h0000_0000_FFFF_FFFF;
        wr(3'd6, 32'h0, 4'b0001);
        idle(1);
        rd(3'd4);
        rd(3'd5);
        idle(3);

        // CLEAR together with FREEZE parks the counter at zero
        wr(3'd6, 32'h3, 4'b0001);
        idle(4);
        rd(3'd4);
        rd(3'd6);
        idle(3);
        // Upper lanes alone must not touch CTRL
        wr(3'd6, 32'h0, 4'b1110);
        rd(3'd6);
        wr(3'd6, 32'h0, 4'b0001);
        idle(3);
        rd(3'd4); rd(3'd5); rd(3'd4); rd(3'd5);
        idle(3);
`endif

        // Collision: write happens, read is discarded
        step(1'b1, 1'b1, 3'd3, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        rd(3'd3);
        idle(3);

        // Read one cycle before reset is dropped; requests during reset ignored
        rd(3'd3);
        step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b1);
        step(1'b0, 1'b1, 3'd3, 32'h5555_5555, 4'b1111, 1'b1);
        idle(3);
        rd(3'd3);
        idle(3);

        // Uptime window and RO writes
        wr(3'd4, 32'hFFFF_FFFF, 4'b1111);
        wr(3'd2, 32'hFFFF_FFFF, 4'b1111);
        rd(3'd4); rd(3'd5); rd(3'd6); rd(3'd2);
        idle(4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            a  = AW'($urandom_range(0, 7));
            r  = ($urandom_range(0, 99) < 60);
            w  = ($urandom_range(0, 99) < 25);
            rs = ($urandom_range(0, 99) == 0);
            step(r, w, a, $urandom, 4'($urandom_range(0, 15)), rs);
        end
        idle(5);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
